// File: rtl/mem_stage_pkg.sv
// Shared types, funct3 encodings and the alignment check for the memory stage.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2,
      OUT  = 2'd3
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Unused funct3 encodings fall through to word-size alignment.
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      case (funct3)
         F3_B, F3_BU: is_misaligned = 1'b0;
         F3_H, F3_HU: is_misaligned = addr_lo[0];
         default:     is_misaligned = (addr_lo != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational store-side byte-enable/data replication and load-side extract/extend.
module lsu_align
   import mem_stage_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] load_word_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] load_data_o
);

   logic [15:0] shifted;

   always_comb begin
      shifted     = 16'(load_word_i >> {addr_lo_i, 3'b000});
      be_o        = 4'b1111;
      wdata_o     = store_data_i;
      load_data_o = load_word_i;
      case (funct3_i)
         F3_B, F3_BU: begin
            be_o        = 4'b0001 << addr_lo_i;
            wdata_o     = {4{store_data_i[7:0]}};
            load_data_o = (funct3_i == F3_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                             : {24'd0, shifted[7:0]};
         end
         F3_H, F3_HU: begin
            be_o        = 4'b0011 << addr_lo_i;
            wdata_o     = {2{store_data_i[15:0]}};
            load_data_o = (funct3_i == F3_H) ? {{16{shifted[15]}}, shifted}
                                             : {16'd0, shifted};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// RISC-V memory stage: one entry per handshake, at most one data-memory access per entry,
// with flush/squash handling and registered write-back payload toward the MEM/WB register.
module mem_access_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned RegAddrWidth     = 4,
   parameter bit          ClearDataOnReset = 1'b0
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    pipeline_flush,
   input  logic                    valid_i,
   output logic                    ready_o,
   input  logic [31:0]             alu_result_i,
   input  logic [31:0]             store_data_i,
   input  logic [2:0]              funct3_i,
   input  logic                    MemRead_i,
   input  logic                    MemWrite_i,
   input  logic [RegAddrWidth-1:0] rd_i,
   input  logic                    RegWrite_i,
   output logic                    dmem_req_o,
   output logic                    dmem_we_o,
   output logic [3:0]              dmem_be_o,
   output logic [31:0]             dmem_addr_o,
   output logic [31:0]             dmem_wdata_o,
   input  logic                    dmem_gnt_i,
   input  logic                    dmem_rvalid_i,
   input  logic [31:0]             dmem_rdata_i,
   output logic                    misaligned_o,
   output logic [31:0]             mem_data_o,
   output logic [31:0]             mem_address_o,
   output logic [RegAddrWidth-1:0] rd_o,
   output logic                    RegWrite_o,
   output logic                    valid_o,
   input  logic                    ready_i
);

   state_t                  state_q, state_d;
   logic                    flushed_q, flushed_d;
   logic                    misaligned_q, misaligned_d;
   logic [31:0]             addr_q, addr_d;
   logic [31:0]             sdata_q, sdata_d;
   logic [2:0]              funct3_q, funct3_d;
   logic                    mem_write_q, mem_write_d;
   logic [RegAddrWidth-1:0] rd_q, rd_d;
   logic                    regwrite_q, regwrite_d;
   logic [31:0]             mem_data_q, mem_data_d;

   logic        ready_c;
   logic        capture_c;
   logic        mis_c;
   logic [31:0] load_data_c;

   lsu_align u_align (
      .funct3_i     (funct3_q),
      .addr_lo_i    (addr_q[1:0]),
      .store_data_i (sdata_q),
      .load_word_i  (dmem_rdata_i),
      .be_o         (dmem_be_o),
      .wdata_o      (dmem_wdata_o),
      .load_data_o  (load_data_c)
   );

   always_comb begin
      state_d      = state_q;
      flushed_d    = flushed_q;
      misaligned_d = 1'b0;
      addr_d       = addr_q;
      sdata_d      = sdata_q;
      funct3_d     = funct3_q;
      mem_write_d  = mem_write_q;
      rd_d         = rd_q;
      regwrite_d   = regwrite_q;
      mem_data_d   = mem_data_q;

      ready_c   = (state_q == IDLE) || ((state_q == OUT) && ready_i);
      capture_c = valid_i && ready_c && !pipeline_flush;
      mis_c     = (MemRead_i || MemWrite_i) && is_misaligned(funct3_i, alu_result_i[1:0]);

      // A flushed transaction still runs to completion, then drops back to IDLE.
      case (state_q)
         REQ: begin
            flushed_d = flushed_q || pipeline_flush;
            if (dmem_gnt_i) begin
               if (mem_write_q) begin
                  state_d   = flushed_d ? IDLE : OUT;
                  flushed_d = 1'b0;
               end else begin
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            flushed_d = flushed_q || pipeline_flush;
            if (dmem_rvalid_i) begin
               mem_data_d = load_data_c;
               state_d    = flushed_d ? IDLE : OUT;
               flushed_d  = 1'b0;
            end
         end
         OUT: begin
            if (pipeline_flush || (ready_i && !valid_i)) state_d = IDLE;
         end
         default: ;
      endcase

      if (capture_c) begin
         addr_d       = alu_result_i;
         sdata_d      = store_data_i;
         funct3_d     = funct3_i;
         mem_write_d  = MemWrite_i;
         rd_d         = rd_i;
         regwrite_d   = RegWrite_i && !mis_c;
         mem_data_d   = alu_result_i;
         misaligned_d = mis_c;
         state_d      = ((MemRead_i || MemWrite_i) && !mis_c) ? REQ : OUT;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         flushed_q    <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         flushed_q    <= flushed_d;
         misaligned_q <= misaligned_d;
      end
   end

   // Payload optionally keeps its contents through reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         if (ClearDataOnReset) begin
            addr_q      <= '0;
            sdata_q     <= '0;
            funct3_q    <= '0;
            mem_write_q <= 1'b0;
            rd_q        <= '0;
            regwrite_q  <= 1'b0;
            mem_data_q  <= '0;
         end
      end else begin
         addr_q      <= addr_d;
         sdata_q     <= sdata_d;
         funct3_q    <= funct3_d;
         mem_write_q <= mem_write_d;
         rd_q        <= rd_d;
         regwrite_q  <= regwrite_d;
         mem_data_q  <= mem_data_d;
      end
   end

   assign ready_o       = ready_c;
   assign valid_o       = (state_q == OUT);
   assign dmem_req_o    = (state_q == REQ);
   assign dmem_we_o     = mem_write_q;
   assign dmem_addr_o   = {addr_q[31:2], 2'b00};
   assign misaligned_o  = misaligned_q;
   assign mem_data_o    = mem_data_q;
   assign mem_address_o = addr_q;
   assign rd_o          = rd_q;
   assign RegWrite_o    = regwrite_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage with hand-computed expectations.
module tb_mem_access_stage;
   import mem_stage_pkg::*;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        pipeline_flush;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] alu_result_i;
   logic [31:0] store_data_i;
   logic [2:0]  funct3_i;
   logic        MemRead_i;
   logic        MemWrite_i;
   logic [3:0]  rd_i;
   logic        RegWrite_i;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic        dmem_gnt_i;
   logic        dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;
   logic        misaligned_o;
   logic [31:0] mem_data_o;
   logic [31:0] mem_address_o;
   logic [3:0]  rd_o;
   logic        RegWrite_o;
   logic        valid_o;
   logic        ready_i;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   mem_access_stage #(.RegAddrWidth(4), .ClearDataOnReset(1'b0)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .pipeline_flush(pipeline_flush),
      .valid_i(valid_i), .ready_o(ready_o), .alu_result_i(alu_result_i),
      .store_data_i(store_data_i), .funct3_i(funct3_i), .MemRead_i(MemRead_i),
      .MemWrite_i(MemWrite_i), .rd_i(rd_i), .RegWrite_i(RegWrite_i),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o),
      .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
      .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
      .misaligned_o(misaligned_o), .mem_data_o(mem_data_o), .mem_address_o(mem_address_o),
      .rd_o(rd_o), .RegWrite_o(RegWrite_o), .valid_o(valid_o), .ready_i(ready_i)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one edge; outputs are sampled 1ns after it.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_op(input logic [31:0] a, input logic [31:0] sd, input logic [2:0] f3,
                           input logic [3:0] rd, input logic mr, input logic mw, input logic rw);
      valid_i      = 1'b1;
      alu_result_i = a;
      store_data_i = sd;
      funct3_i     = f3;
      rd_i         = rd;
      MemRead_i    = mr;
      MemWrite_i   = mw;
      RegWrite_i   = rw;
   endtask

   task automatic do_store(input string tag, input logic [31:0] a, input logic [31:0] sd,
                           input logic [2:0] f3, input int gnt_delay,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd);
      drive_op(a, sd, f3, 4'd1, 1'b0, 1'b1, 1'b0);
      tick();
      valid_i = 1'b0;
      for (int i = 0; i <= gnt_delay; i++) begin
         dmem_gnt_i = (i == gnt_delay);
         #1;
         check_eq({tag, "_req"},   32'(dmem_req_o), 32'd1);
         check_eq({tag, "_we"},    32'(dmem_we_o), 32'd1);
         check_eq({tag, "_be"},    32'(dmem_be_o), 32'(exp_be));
         check_eq({tag, "_addr"},  dmem_addr_o, {a[31:2], 2'b00});
         check_eq({tag, "_wdata"}, dmem_wdata_o, exp_wd);
         check_eq({tag, "_rdy"},   32'(ready_o), 32'd0);
         check_eq({tag, "_vld"},   32'(valid_o), 32'd0);
         tick();
      end
      dmem_gnt_i = 1'b0;
      check_eq({tag, "_out_vld"}, 32'(valid_o), 32'd1);
      check_eq({tag, "_out_req"}, 32'(dmem_req_o), 32'd0);
      check_eq({tag, "_out_adr"}, mem_address_o, a);
      tick();
      check_eq({tag, "_idle"}, 32'(valid_o), 32'd0);
   endtask

   task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] rdata, input logic [31:0] exp);
      drive_op(a, 32'd0, f3, 4'd7, 1'b1, 1'b0, 1'b1);
      tick();
      valid_i = 1'b0;
      dmem_gnt_i    = 1'b1;
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = 32'hDEAD_BEEF;
      #1;
      check_eq({tag, "_req"}, 32'(dmem_req_o), 32'd1);
      check_eq({tag, "_we"},  32'(dmem_we_o), 32'd0);
      tick();
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b0;
      check_eq({tag, "_resp_vld"}, 32'(valid_o), 32'd0);
      check_eq({tag, "_resp_req"}, 32'(dmem_req_o), 32'd0);
      tick();
      check_eq({tag, "_wait_vld"}, 32'(valid_o), 32'd0);
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = rdata;
      tick();
      dmem_rvalid_i = 1'b0;
      check_eq({tag, "_vld"},  32'(valid_o), 32'd1);
      check_eq({tag, "_data"}, mem_data_o, exp);
      check_eq({tag, "_rd"},   32'(rd_o), 32'd7);
      check_eq({tag, "_rw"},   32'(RegWrite_o), 32'd1);
      tick();
   endtask

   initial begin
      reset_i = 1'b1; pipeline_flush = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
      alu_result_i = '0; store_data_i = '0; funct3_i = F3_W; rd_i = '0;
      MemRead_i = 1'b0; MemWrite_i = 1'b0; RegWrite_i = 1'b0;
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
      tick(); tick();
      reset_i = 1'b0;
      #1;
      check_eq("rst_valid", 32'(valid_o), 32'd0);
      check_eq("rst_req",   32'(dmem_req_o), 32'd0);
      check_eq("rst_mis",   32'(misaligned_o), 32'd0);
      check_eq("rst_ready", 32'(ready_o), 32'd1);

      // Non-memory op: valid one cycle after capture.
      drive_op(32'h1234, 32'd0, F3_W, 4'd5, 1'b0, 1'b0, 1'b1);
      tick();
      valid_i = 1'b0;
      check_eq("alu_vld",  32'(valid_o), 32'd1);
      check_eq("alu_data", mem_data_o, 32'h1234);
      check_eq("alu_adr",  mem_address_o, 32'h1234);
      check_eq("alu_rd",   32'(rd_o), 32'd5);
      check_eq("alu_rw",   32'(RegWrite_o), 32'd1);
      check_eq("alu_req",  32'(dmem_req_o), 32'd0);
      tick();
      check_eq("alu_idle", 32'(valid_o), 32'd0);

      do_store("sb", 32'h103, 32'h0000_00AB, F3_B, 3, 4'b1000, 32'hABAB_ABAB);
      do_store("sh", 32'h102, 32'h0000_BEEF, F3_H, 0, 4'b1100, 32'hBEEF_BEEF);
      do_store("sw", 32'h10C, 32'hCAFE_F00D, F3_W, 1, 4'b1111, 32'hCAFE_F00D);

      do_load("lb",  32'h202, F3_B,  32'h0080_FF00, 32'hFFFF_FF80);
      do_load("lbu", 32'h202, F3_BU, 32'h0080_FF00, 32'h0000_0080);
      do_load("lh",  32'h202, F3_H,  32'h0080_FF00, 32'h0000_0080);
      do_load("lh0", 32'h200, F3_H,  32'h0000_8001, 32'hFFFF_8001);
      do_load("lhu", 32'h200, F3_HU, 32'h0000_8001, 32'h0000_8001);
      do_load("lbu3",32'h203, F3_BU, 32'hA500_0000, 32'h0000_00A5);
      do_load("lw",  32'h204, F3_W,  32'h1357_9BDF, 32'h1357_9BDF);

      // Misaligned word load is dropped without a request.
      drive_op(32'h206, 32'd0, F3_W, 4'd9, 1'b1, 1'b0, 1'b1);
      tick();
      valid_i = 1'b0;
      check_eq("mis_pulse", 32'(misaligned_o), 32'd1);
      check_eq("mis_req",   32'(dmem_req_o), 32'd0);
      check_eq("mis_vld",   32'(valid_o), 32'd1);
      check_eq("mis_rw",    32'(RegWrite_o), 32'd0);
      check_eq("mis_rd",    32'(rd_o), 32'd9);
      tick();
      check_eq("mis_clr",   32'(misaligned_o), 32'd0);
      check_eq("mis_idle",  32'(valid_o), 32'd0);

      // Backpressure holds payload, then back-to-back ALU ops.
      drive_op(32'h55, 32'd0, F3_W, 4'd3, 1'b0, 1'b0, 1'b1);
      ready_i = 1'b0;
      tick();
      drive_op(32'h66, 32'd0, F3_W, 4'd4, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         #1;
         check_eq("bp_rdy",  32'(ready_o), 32'd0);
         check_eq("bp_vld",  32'(valid_o), 32'd1);
         check_eq("bp_data", mem_data_o, 32'h55);
         check_eq("bp_rd",   32'(rd_o), 32'd3);
         tick();
      end
      ready_i = 1'b1;
      #1;
      check_eq("bp_rdy_up", 32'(ready_o), 32'd1);
      tick();
      drive_op(32'h77, 32'd0, F3_W, 4'd6, 1'b0, 1'b0, 1'b1);
      check_eq("b2b_vld0", 32'(valid_o), 32'd1);
      check_eq("b2b_d0",   mem_data_o, 32'h66);
      check_eq("b2b_rd0",  32'(rd_o), 32'd4);
      tick();
      valid_i = 1'b0;
      check_eq("b2b_vld1", 32'(valid_o), 32'd1);
      check_eq("b2b_d1",   mem_data_o, 32'h77);
      tick();
      check_eq("b2b_idle", 32'(valid_o), 32'd0);

      // Flush during RESP: rvalid is consumed, no output.
      drive_op(32'h300, 32'd0, F3_W, 4'd8, 1'b1, 1'b0, 1'b1);
      tick();
      valid_i = 1'b0;
      dmem_gnt_i = 1'b1;
      tick();
      dmem_gnt_i = 1'b0;
      pipeline_flush = 1'b1;
      tick();
      pipeline_flush = 1'b0;
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = 32'h1111_1111;
      tick();
      dmem_rvalid_i = 1'b0;
      #1;
      check_eq("flr_vld", 32'(valid_o), 32'd0);
      check_eq("flr_rdy", 32'(ready_o), 32'd1);
      check_eq("flr_req", 32'(dmem_req_o), 32'd0);
      tick();
      check_eq("flr_vld2", 32'(valid_o), 32'd0);

      // Flag cleared: next op completes normally.
      drive_op(32'hABC, 32'd0, F3_W, 4'd2, 1'b0, 1'b0, 1'b1);
      tick();
      check_eq("post_vld",  32'(valid_o), 32'd1);
      check_eq("post_data", mem_data_o, 32'hABC);

      // Flush in OUT overrides a simultaneous capture.
      drive_op(32'hDEF, 32'd0, F3_W, 4'd1, 1'b0, 1'b0, 1'b1);
      pipeline_flush = 1'b1;
      tick();
      pipeline_flush = 1'b0;
      valid_i = 1'b0;
      check_eq("flo_vld",  32'(valid_o), 32'd0);
      check_eq("flo_data", mem_data_o, 32'hABC);

      // Flush in IDLE ignores valid_i.
      drive_op(32'h500, 32'd0, F3_W, 4'd1, 1'b1, 1'b0, 1'b1);
      pipeline_flush = 1'b1;
      tick();
      pipeline_flush = 1'b0;
      valid_i = 1'b0;
      check_eq("fli_req", 32'(dmem_req_o), 32'd0);
      check_eq("fli_vld", 32'(valid_o), 32'd0);

      // Reset in REQ abandons the request; late rvalid is ignored.
      drive_op(32'h400, 32'h1234_5678, F3_W, 4'd1, 1'b0, 1'b1, 1'b0);
      tick();
      valid_i = 1'b0;
      check_eq("rr_req", 32'(dmem_req_o), 32'd1);
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      check_eq("rr_req_off", 32'(dmem_req_o), 32'd0);
      check_eq("rr_vld",     32'(valid_o), 32'd0);
      dmem_rvalid_i = 1'b1;
      tick();
      dmem_rvalid_i = 1'b0;
      check_eq("rr_late_vld", 32'(valid_o), 32'd0);
      check_eq("rr_late_rdy", 32'(ready_o), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
